acia_rx: RTL and testbench
==========================

Name: acia_rx

Overview:
- Receive half of the 6551-compatible ACIA; pairs with the existing transmitter.
- Deserialises async RXD frames (start, 8 data LSB-first, optional parity, stop) using 16x oversampling from a BCLK-derived enable.
- Holds one received byte plus status flags (RXFULL, PERR, FERR, OVRN) for the register-interface block, which reads them in the PHI2 domain.

Parameters:
- OVERSAMPLE, 16: BCLK_EN ticks per bit. Power of two, >=4. Mid-bit sample point is tick OVERSAMPLE/2-1.
- SYNC_STAGES, 2: flip-flop depth of the RXD synchroniser, >=2.

Ports:
- PHI2  input  1  system clock; all logic on its rising edge
- RESET  input  1  asynchronous, active-high reset
- BCLK_EN  input  1  one-PHI2-cycle pulse at 16x baud rate
- RXD  input  1  serial line, idle high, asynchronous
- R_PME  input  1  parity enable
- R_PMC  input  2  parity mode: 00 odd, 01 even, 10 mark, 11 space
- RXREAD  input  1  one-cycle strobe: CPU has read the data register
- RXDATA  output  8  last accepted byte
- RXFULL  output  1  RXDATA holds an unread byte
- PERR  output  1  parity error on the byte in RXDATA
- FERR  output  1  framing error (stop bit sampled 0)
- OVRN  output  1  a frame completed while RXFULL=1
- RXBUSY  output  1  FSM not in Idle

Behaviour:
- Reset (async, while RESET=1): RXDATA=0x00; RXFULL, PERR, FERR, OVRN, RXBUSY=0; FSM=Idle; tick/bit counters=0; synchroniser preset to 1.
- RXD passes through SYNC_STAGES flops; FSM uses only the synchronised value rxs. Tick counter and FSM advance only on cycles with BCLK_EN=1.
- Idle: tick counter=0. rxs=0 -> Start.
- Start: count ticks. At the sample point:
  - rxs=1 -> false start, back to Idle, nothing flagged.
  - rxs=0 -> tick counter=0, enter Data.
- Data: sample rxs at each bit's sample point and shift it into bit 7 of the shift register (LSB-first). Running parity = XOR of data bits. After bit 7 -> Parity if R_PME=1, else Stop.
- Parity: sample at sample point. Expected bit: odd = ~xor, even = xor, mark = 1, space = 0. Mismatch sets internal perr_n. R_PMC/R_PME are sampled live; software changes them only while idle.
- Stop: sample at sample point (frame-complete point); same PHI2 cycle performs commit:
  - RXFULL=0: RXDATA<=shift reg, RXFULL<=1, PERR<=perr_n, FERR<=(rxs==0), OVRN<=0.
  - RXFULL=1: RXDATA, PERR, FERR unchanged; OVRN<=1 (new byte discarded).
  - Then rxs=1 -> Idle. rxs=0 -> BrkWait.
- Receiver checks one stop bit only; R_SBN is not an input.
- BrkWait: stay until rxs=1 on a BCLK_EN tick, then Idle. Break (line held low) yields exactly one commit: 0x00 with FERR=1.
- RXREAD=1: clears RXFULL, PERR, FERR, OVRN next cycle. If RXREAD and a commit occur in the same cycle, the commit wins: new byte loaded, RXFULL=1, OVRN=0.
- Status outputs update 1 PHI2 cycle after the commit tick. End-to-end latency from RXD edge = SYNC_STAGES cycles plus tick timing.
- RESET asserted mid-frame: frame is abandoned. After release, a line held low is treated as a fresh start edge.
- RXBUSY=1 in Start, Data, Parity, Stop, BrkWait.

Test Plan:
- 8N1 frame 0xA5, BCLK_EN every 4 PHI2 cycles -> RXDATA=0xA5, RXFULL=1, PERR=FERR=OVRN=0; RXREAD pulse -> RXFULL=0 next cycle.
- R_PME=1, R_PMC=01, byte 0x01 with parity bit 1 -> PERR=0. Same byte with parity bit 0 -> PERR=1. R_PMC=10 with parity bit 0 -> PERR=1.
- RXD low for 4 ticks then high (glitch) -> RXBUSY returns to 0, RXFULL stays 0. Following valid 0x3C is received correctly.
- Two frames 0x11 then 0x22 without RXREAD -> RXDATA=0x11, OVRN=1. RXREAD in the same cycle as the second commit -> RXDATA=0x22, RXFULL=1, OVRN=0.
- Break: RXD low for 20 bit-times -> single commit 0x00, FERR=1, RXBUSY=1 until RXD high. Next frame 0x7E received, FERR cleared after the RXREAD.
- RESET pulsed during data bit 3 -> all outputs 0 immediately. Subsequent frame 0xC3 is received cleanly.

Source files
------------

// File: rtl/acia_rx.sv
// acia_rx: receive half of a 6551-compatible ACIA.
// Oversampled async receiver (start, 8 data bits LSB-first, optional parity,
// one stop bit) holding a single byte plus RXFULL/PERR/FERR/OVRN status.
module acia_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       BCLK_EN,
  input  logic       RXD,
  input  logic       R_PME,
  input  logic [1:0] R_PMC,
  input  logic       RXREAD,
  output logic [7:0] RXDATA,
  output logic       RXFULL,
  output logic       PERR,
  output logic       FERR,
  output logic       OVRN,
  output logic       RXBUSY
);

  localparam int TW = $clog2(OVERSAMPLE);
  // Start bit is checked half a bit after the falling edge is seen.
  localparam logic [TW-1:0] C_SAMPLE = TW'(OVERSAMPLE / 2 - 1);
  // The counter restarts at the mid-start sample, so one full bit period
  // later lands on the middle of every following bit.
  localparam logic [TW-1:0] C_LAST   = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  state_t                 r_state;
  logic [TW-1:0]          r_tick;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic                   r_perr_pend;

  // Parity bit the sender should have sent for a given mode and data XOR.
  function automatic logic f_exp_parity(input logic [1:0] mode, input logic xr);
    case (mode)
      2'b00:   f_exp_parity = ~xr;
      2'b01:   f_exp_parity = xr;
      2'b10:   f_exp_parity = 1'b1;
      2'b11:   f_exp_parity = 1'b0;
      default: f_exp_parity = 1'b0;
    endcase
  endfunction

  // Bring RXD into the PHI2 domain; preset high so reset looks like an idle line.
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], RXD};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // Frame FSM, shift register and status flags; a commit overrides a same-cycle read.
  always_ff @(posedge PHI2 or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_tick      <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_par       <= 1'b0;
      r_perr_pend <= 1'b0;
      RXDATA      <= 8'h00;
      RXFULL      <= 1'b0;
      PERR        <= 1'b0;
      FERR        <= 1'b0;
      OVRN        <= 1'b0;
      RXBUSY      <= 1'b0;
    end else begin
      if (RXREAD) begin
        RXFULL <= 1'b0;
        PERR   <= 1'b0;
        FERR   <= 1'b0;
        OVRN   <= 1'b0;
      end
      if (BCLK_EN) begin
        case (r_state)
          S_IDLE: begin
            r_tick <= '0;
            if (!w_rxs) begin
              r_state <= S_START;
              RXBUSY  <= 1'b1;
            end
          end
          S_START: begin
            if (r_tick == C_SAMPLE) begin
              r_tick <= '0;
              if (w_rxs) begin
                r_state <= S_IDLE;
                RXBUSY  <= 1'b0;
              end else begin
                r_state     <= S_DATA;
                r_bit       <= 3'd0;
                r_par       <= 1'b0;
                r_perr_pend <= 1'b0;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_DATA: begin
            if (r_tick == C_LAST) begin
              r_tick  <= '0;
              r_shift <= {w_rxs, r_shift[7:1]};
              r_par   <= r_par ^ w_rxs;
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) begin
                r_state <= R_PME ? S_PARITY : S_STOP;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_PARITY: begin
            if (r_tick == C_LAST) begin
              r_tick      <= '0;
              r_perr_pend <= (w_rxs != f_exp_parity(R_PMC, r_par));
              r_state     <= S_STOP;
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_STOP: begin
            if (r_tick == C_LAST) begin
              r_tick <= '0;
              // A read in this same cycle frees the holding register for the new byte.
              if (!RXFULL || RXREAD) begin
                RXDATA <= r_shift;
                RXFULL <= 1'b1;
                PERR   <= r_perr_pend;
                FERR   <= ~w_rxs;
                OVRN   <= 1'b0;
              end else begin
                OVRN <= 1'b1;
              end
              if (w_rxs) begin
                r_state <= S_IDLE;
                RXBUSY  <= 1'b0;
              end else begin
                r_state <= S_BRKWAIT;
              end
            end else begin
              r_tick <= r_tick + TW'(1);
            end
          end
          S_BRKWAIT: begin
            if (w_rxs) begin
              r_state <= S_IDLE;
              RXBUSY  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            RXBUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acia_rx.sv
// tb_acia_rx: directed plus randomized frames checked against a frame-level model.
module tb_acia_rx;

  logic       PHI2    = 1'b0;
  logic       RESET   = 1'b1;
  logic       BCLK_EN = 1'b0;
  logic       RXD     = 1'b1;
  logic       R_PME   = 1'b0;
  logic [1:0] R_PMC   = 2'b00;
  logic       RXREAD  = 1'b0;
  logic [7:0] RXDATA;
  logic       RXFULL, PERR, FERR, OVRN, RXBUSY;

  int n_cmp = 0;
  int n_err = 0;
  int div   = 0;

  // frame-level reference model of the holding register
  logic [7:0] m_data = 8'h00;
  logic       m_full = 1'b0;
  logic       m_perr = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovrn = 1'b0;

  acia_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .PHI2(PHI2), .RESET(RESET), .BCLK_EN(BCLK_EN), .RXD(RXD),
    .R_PME(R_PME), .R_PMC(R_PMC), .RXREAD(RXREAD),
    .RXDATA(RXDATA), .RXFULL(RXFULL), .PERR(PERR), .FERR(FERR),
    .OVRN(OVRN), .RXBUSY(RXBUSY)
  );

  always #5 PHI2 = ~PHI2;

  // baud enable: one PHI2 cycle in every four
  initial begin
    forever begin
      @(posedge PHI2);
      #1;
      div = (div + 1) % 4;
      BCLK_EN = (div == 0);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy);
    chk({tag, ".data"}, RXDATA, m_data);
    chk({tag, ".full"}, {7'd0, RXFULL}, {7'd0, m_full});
    chk({tag, ".perr"}, {7'd0, PERR},   {7'd0, m_perr});
    chk({tag, ".ferr"}, {7'd0, FERR},   {7'd0, m_ferr});
    chk({tag, ".ovrn"}, {7'd0, OVRN},   {7'd0, m_ovrn});
    chk({tag, ".busy"}, {7'd0, RXBUSY}, {7'd0, exp_busy});
  endtask

  task automatic model_read();
    m_full = 1'b0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovrn = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] d, input logic pe, input logic fe);
    if (!m_full) begin
      m_data = d;
      m_full = 1'b1;
      m_perr = pe;
      m_ferr = fe;
      m_ovrn = 1'b0;
    end else begin
      m_ovrn = 1'b1;
    end
  endtask

  function automatic logic exp_par(input logic [1:0] mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (mode == 2'b00) return (ones % 2 == 0);   // odd: total count of ones odd
    if (mode == 2'b01) return (ones % 2 == 1);   // even
    if (mode == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  // wait for the next baud tick edge, then step clear of it
  task automatic tick();
    do @(posedge PHI2); while (BCLK_EN !== 1'b1);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_read(input string tag);
    RXREAD = 1'b1;
    @(posedge PHI2);
    #2;
    RXREAD = 1'b0;
    model_read();
    check_all(tag, 1'b0);
  endtask

  // one whole frame; optionally strobe RXREAD on the stop-bit sample cycle
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopv, input logic rd_at_commit);
    tick();
    RXD = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      ticks(16);
    end
    if (pen) begin
      RXD = pbit;
      ticks(16);
    end
    RXD = stopv;
    ticks(8);
    repeat (3) @(posedge PHI2);
    #2;
    RXREAD = rd_at_commit;
    @(posedge PHI2);
    #2;
    RXREAD = 1'b0;
    ticks(7);
    RXD = 1'b1;
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] d, input logic pbit,
                           input logic stopv, input logic rd_at_commit);
    logic pe;
    pe = R_PME ? (pbit != exp_par(R_PMC, d)) : 1'b0;
    send_frame(d, R_PME, pbit, stopv, rd_at_commit);
    if (rd_at_commit) model_read();
    model_commit(d, pe, ~stopv);
    ticks(4);
    check_all(tag, 1'b0);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rb;
    #12;
    check_all("reset", 1'b0);
    @(posedge PHI2);
    #2;
    RESET = 1'b0;
    ticks(4);

    // plain 8N1
    frame_chk("a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    do_read("a5_read");

    // parity modes
    R_PME = 1'b1;
    R_PMC = 2'b01;
    frame_chk("even_ok", 8'h01, 1'b1, 1'b1, 1'b0);
    do_read("even_ok_read");
    frame_chk("even_bad", 8'h01, 1'b0, 1'b1, 1'b0);
    do_read("even_bad_read");
    R_PMC = 2'b10;
    frame_chk("mark_bad", 8'h01, 1'b0, 1'b1, 1'b0);
    do_read("mark_bad_read");
    R_PME = 1'b0;

    // glitch shorter than half a bit
    tick();
    RXD = 1'b0;
    ticks(3);
    chk("glitch.busy_hi", {7'd0, RXBUSY}, 8'h01);
    ticks(1);
    RXD = 1'b1;
    ticks(32);
    check_all("glitch_after", 1'b0);
    frame_chk("3c", 8'h3C, 1'b0, 1'b1, 1'b0);
    do_read("3c_read");

    // overrun, then read coinciding with commit
    frame_chk("ov_first", 8'h11, 1'b0, 1'b1, 1'b0);
    frame_chk("ov_second", 8'h22, 1'b0, 1'b1, 1'b0);
    do_read("ov_read");
    frame_chk("rc_first", 8'h11, 1'b0, 1'b1, 1'b0);
    frame_chk("rc_second", 8'h22, 1'b0, 1'b1, 1'b1);
    do_read("rc_read");

    // break: 20 bit-times low
    tick();
    RXD = 1'b0;
    ticks(16 * 12);
    model_commit(8'h00, 1'b0, 1'b1);
    check_all("brk_mid", 1'b1);
    ticks(16 * 8);
    check_all("brk_end", 1'b1);
    RXD = 1'b1;
    ticks(4);
    check_all("brk_released", 1'b0);
    do_read("brk_read");
    frame_chk("7e", 8'h7E, 1'b0, 1'b1, 1'b0);
    do_read("7e_read");

    // reset during data bit 3
    frame_chk("pre_rst", 8'($urandom), 1'b0, 1'b1, 1'b0);
    tick();
    RXD = 1'b0;
    ticks(16);
    rd = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      RXD = rd[i];
      ticks(i == 3 ? 8 : 16);
    end
    RESET = 1'b1;
    #1;
    m_data = 8'h00;
    model_read();
    check_all("mid_reset", 1'b0);
    RXD = 1'b1;
    @(posedge PHI2);
    #2;
    RESET = 1'b0;
    ticks(4);
    frame_chk("c3", 8'hC3, 1'b0, 1'b1, 1'b0);
    do_read("c3_read");

    // randomized frames
    for (int k = 0; k < 8; k++) begin
      rd    = 8'($urandom);
      R_PME = 1'($urandom);
      R_PMC = 2'($urandom);
      rb    = 1'($urandom);
      if ($urandom_range(0, 1) == 0) do_read("rnd_pre_read");
      frame_chk("rnd", rd, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
